// File: rtl/reg_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_bank
// Description : Write side of the register file. Decoded, per-register enabled
//               storage with a hardwired-zero register and a write-commit pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 31
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 write_enable,
    input  logic [4:0]                           write_reg,
    input  logic [DATA_WIDTH-1:0]                write_data,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_data,
    output logic                                 write_done,
    output logic [4:0]                           last_reg
);

    localparam int c_ADDR_W = 5;

    logic [NUM_REGS-1:0] w_wr_en;
    logic                w_commit;
    logic                r_write_done;
    logic [4:0]          r_last_reg;

    // One flop bank per register; the zero register has no storage at all.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign w_wr_en[i]  = 1'b0;
            assign reg_data[i] = '0;
        end else begin : g_store
            logic [DATA_WIDTH-1:0] r_q;

            // Gating by write_enable first keeps an unknown address harmless when idle.
            assign w_wr_en[i] = write_enable && (write_reg == c_ADDR_W'(i));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_wr_en[i]) begin
                    r_q <= write_data;
                end
            end

            assign reg_data[i] = r_q;
        end
    end

    // A commit is any live register enable, so writes to the zero register never count.
    assign w_commit = |w_wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_done <= 1'b0;
            r_last_reg   <= '0;
        end else begin
            r_write_done <= w_commit;
            if (w_commit) begin
                r_last_reg <= write_reg;
            end
        end
    end

    assign write_done = r_write_done;
    assign last_reg   = r_last_reg;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_bank
// Description : Scoreboard bench for reg_write_bank with a register-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_bank;

    localparam int c_DW = 64;
    localparam int c_NR = 32;
    localparam int c_ZR = 31;

    logic                        clk;
    logic                        reset;
    logic                        write_enable;
    logic [4:0]                  write_reg;
    logic [c_DW-1:0]             write_data;
    logic [c_NR-1:0][c_DW-1:0]   reg_data;
    logic                        write_done;
    logic [4:0]                  last_reg;

    // Read mux standing in for the datapath's 32:1 operand select.
    logic [4:0]                  rd_sel;
    logic [c_DW-1:0]             rd_data;
    assign rd_data = reg_data[rd_sel];

    reg_write_bank #(
        .DATA_WIDTH (c_DW),
        .NUM_REGS   (c_NR),
        .ZERO_REG   (c_ZR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .reg_data     (reg_data),
        .write_done   (write_done),
        .last_reg     (last_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_NR-1:0][c_DW-1:0] regs;
        logic                      done;
        logic [4:0]                last;
        logic [c_DW-1:0]           rd;
        logic [8*8-1:0]            name;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Architectural model: what software would see in X0..X30 after each edge.
    logic [c_DW-1:0] m_regs [c_NR];
    logic            m_done;
    logic [4:0]      m_last;

    task automatic model_clear();
        for (int k = 0; k < c_NR; k++) m_regs[k] = '0;
        m_done = 1'b0;
        m_last = '0;
    endtask

    task automatic model_edge(input logic we, input logic [4:0] wr, input logic [c_DW-1:0] wd);
        m_done = we && (int'(wr) != c_ZR);
        if (m_done) begin
            m_regs[wr] = wd;
            m_last     = wr;
        end
    endtask

    // Drive one cycle of inputs just after the edge; the pushed entry describes
    // the state the DUT should show before the next edge.
    task automatic step(input logic rst_v, input logic we, input logic [4:0] wr,
                        input logic [c_DW-1:0] wd, input logic [4:0] rs,
                        input logic [8*8-1:0] nm);
        exp_t e;
        @(posedge clk);
        #2;
        reset        = rst_v;
        write_enable = we;
        write_reg    = wr;
        write_data   = wd;
        rd_sel       = rs;
        if (rst_v) model_clear();
        for (int k = 0; k < c_NR; k++) e.regs[k] = m_regs[k];
        e.done = m_done;
        e.last = m_last;
        e.rd   = m_regs[rs];
        e.name = nm;
        sb.push_back(e);
        if (rst_v) model_clear();
        else       model_edge(we, wr, wd);
    endtask

    // Monitor: every negedge, the oldest outstanding expectation is due.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            int   first;
            e = sb.pop_front();
            first = -1;
            for (int k = c_NR - 1; k >= 0; k--) if (reg_data[k] !== e.regs[k]) first = k;
            n_cmp++;
            if (first >= 0) begin
                n_bad++;
                $display("FAIL %0s reg_data[%0d]: got %h expected %h", e.name, first,
                         reg_data[first], e.regs[first]);
            end
            n_cmp++;
            if (write_done !== e.done) begin
                n_bad++;
                $display("FAIL %0s write_done: got %b expected %b", e.name, write_done, e.done);
            end
            n_cmp++;
            if (last_reg !== e.last) begin
                n_bad++;
                $display("FAIL %0s last_reg: got %0d expected %0d", e.name, last_reg, e.last);
            end
            n_cmp++;
            if (rd_data !== e.rd) begin
                n_bad++;
                $display("FAIL %0s read_mux X%0d: got %h expected %h", e.name, rd_sel,
                         rd_data, e.rd);
            end
        end
    end

    initial begin
        logic [c_DW-1:0] d;
        reset        = 1'b1;
        write_enable = 1'b0;
        write_reg    = '0;
        write_data   = '0;
        rd_sel       = '0;
        model_clear();

        step(1'b1, 1'b1, 5'd4, 64'h1234, 5'd4, "rst_hold");
        step(1'b0, 1'b0, 5'd0, 64'h0,    5'd0, "rst_idle");

        // Load X5, then assert reset mid-cycle while a write is pending.
        step(1'b0, 1'b1, 5'd5, 64'hA5A5, 5'd5, "load_x5");
        step(1'b0, 1'b0, 5'd0, 64'h0,    5'd5, "x5_set");
        step(1'b1, 1'b1, 5'd9, 64'hBEEF, 5'd5, "rst_mid");
        step(1'b1, 1'b1, 5'd9, 64'hBEEF, 5'd9, "rst_wr");
        step(1'b0, 1'b1, 5'd6, 64'h66,   5'd6, "first_wr");

        for (int i = 0; i < c_ZR; i++) begin
            d = 64'h1111_1111_1111_1111 * 64'(i) + 64'(i);
            step(1'b0, 1'b1, 5'(i), d, 5'(i), "sweep");
        end

        step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, "xzr_wr");
        step(1'b0, 1'b0, 5'd7,  64'hDEAD, 5'd31, "xzr_chk");
        step(1'b0, 1'b0, 5'd7,  64'hDEAD, 5'd7,  "en_low");
        step(1'b0, 1'b1, 5'd3,  64'h1,    5'd3,  "b2b_1");
        step(1'b0, 1'b1, 5'd3,  64'h2,    5'd3,  "b2b_2");
        step(1'b0, 1'b0, 5'd0,  64'h0,    5'd3,  "b2b_end");
        step(1'b0, 1'b1, 5'd2,  64'hC0DE_0002, 5'd2, "rdw_x2");
        step(1'b0, 1'b0, 5'd2,  64'h0,    5'd2,  "rdw_new");

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 31)),
                 {$urandom, $urandom},
                 5'($urandom_range(0, 31)),
                 "random");
        end
        step(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, "final");

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
